// File: rtl/cpu_pkg.sv
// Shared state codes and opcodes for the 8-bit CPU.
// The control FSM and the address unit both import these constants.
package cpu_pkg;

    localparam int DATA_W = 8;

    // Control FSM state codes
    localparam logic [DATA_W-1:0] STATE_NEXT       = 8'h00;
    localparam logic [DATA_W-1:0] STATE_FETCH_PC   = 8'h01;
    localparam logic [DATA_W-1:0] STATE_FETCH_INST = 8'h02;
    localparam logic [DATA_W-1:0] STATE_HALT       = 8'h03;
    localparam logic [DATA_W-1:0] STATE_JUMP       = 8'h04;
    localparam logic [DATA_W-1:0] STATE_OUT        = 8'h05;
    localparam logic [DATA_W-1:0] STATE_ALU_OUT    = 8'h06;
    localparam logic [DATA_W-1:0] STATE_ALU_EXEC   = 8'h07;
    localparam logic [DATA_W-1:0] STATE_MOV_STORE  = 8'h08;
    localparam logic [DATA_W-1:0] STATE_MOV_FETCH  = 8'h09;
    localparam logic [DATA_W-1:0] STATE_MOV_LOAD   = 8'h0A;
    localparam logic [DATA_W-1:0] STATE_FETCH_SP   = 8'h0C;
    localparam logic [DATA_W-1:0] STATE_PC_STORE   = 8'h0D;
    localparam logic [DATA_W-1:0] STATE_TMP_JUMP   = 8'h0E;
    localparam logic [DATA_W-1:0] STATE_RET        = 8'h0F;
    localparam logic [DATA_W-1:0] STATE_INC_SP     = 8'h10;
    localparam logic [DATA_W-1:0] STATE_SET_ADDR   = 8'h11;
    localparam logic [DATA_W-1:0] STATE_IN         = 8'h12;
    localparam logic [DATA_W-1:0] STATE_REG_STORE  = 8'h13;
    localparam logic [DATA_W-1:0] STATE_SET_REG    = 8'h14;

    // Instruction opcodes as decoded by the control FSM
    localparam logic [DATA_W-1:0] OP_NOP  = 8'h00;
    localparam logic [DATA_W-1:0] OP_HALT = 8'h01;
    localparam logic [DATA_W-1:0] OP_JMP  = 8'h02;
    localparam logic [DATA_W-1:0] OP_MOV  = 8'h03;
    localparam logic [DATA_W-1:0] OP_ALU  = 8'h04;
    localparam logic [DATA_W-1:0] OP_IN   = 8'h05;
    localparam logic [DATA_W-1:0] OP_OUT  = 8'h06;
    localparam logic [DATA_W-1:0] OP_PUSH = 8'h07;
    localparam logic [DATA_W-1:0] OP_POP  = 8'h08;
    localparam logic [DATA_W-1:0] OP_CALL = 8'h09;
    localparam logic [DATA_W-1:0] OP_RET  = 8'h0A;
    localparam logic [DATA_W-1:0] OP_SET  = 8'h0B;

endpackage

// File: rtl/cpu_addr_unit.sv
// Address and sequencing datapath: PC, SP, MAR, IR, TMP and I/O address latch,
// driven directly by the control FSM state code.
module cpu_addr_unit
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] PC_RESET = 8'h00,
    parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] state,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] io_addr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] sp,
    output logic              halted,
    output logic              stack_err,
    output logic              bad_state
);

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] sp_q;
    logic [DATA_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] tmp;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q      <= PC_RESET;
            sp_q      <= SP_RESET;
            mar       <= '0;
            ir        <= '0;
            tmp       <= '0;
            io_addr   <= '0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
            bad_state <= 1'b0;
        end else begin
            stack_err <= 1'b0;
            bad_state <= 1'b0;
            // Once halted, only reset brings the unit back.
            if (!halted) begin
                case (state)
                    STATE_FETCH_PC: begin
                        mar  <= pc_q;
                        pc_q <= pc_q + 8'd1;
                    end
                    STATE_FETCH_INST: ir      <= mem_rdata;
                    STATE_HALT:       halted  <= 1'b1;
                    STATE_JUMP:       pc_q    <= mem_rdata;
                    STATE_SET_REG:    tmp     <= mem_rdata;
                    STATE_SET_ADDR:   io_addr <= mem_rdata;
                    STATE_FETCH_SP:   mar     <= sp_q;
                    STATE_REG_STORE,
                    STATE_PC_STORE: begin
                        sp_q      <= sp_q - 8'd1;
                        stack_err <= (sp_q == 8'h00);
                    end
                    STATE_TMP_JUMP:   pc_q    <= tmp;
                    STATE_INC_SP: begin
                        sp_q      <= sp_q + 8'd1;
                        stack_err <= (sp_q == 8'hFF);
                    end
                    STATE_RET:        pc_q    <= mem_rdata;
                    STATE_NEXT, STATE_OUT, STATE_IN, STATE_ALU_OUT,
                    STATE_ALU_EXEC, STATE_MOV_STORE, STATE_MOV_FETCH,
                    STATE_MOV_LOAD: ;
                    default:          bad_state <= 1'b1;
                endcase
            end
        end
    end

    // Writes happen at the same edge the store state is sampled, so the strobe is combinational.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (reset_n && !halted) begin
            case (state)
                STATE_REG_STORE: begin
                    mem_we    = 1'b1;
                    mem_wdata = reg_data;
                end
                STATE_PC_STORE: begin
                    mem_we    = 1'b1;
                    mem_wdata = pc_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = mar;
    assign instruction = ir;
    assign pc          = pc_q;
    assign sp          = sp_q;

endmodule

// File: doc/cpu_addr_unit.md
# cpu_addr_unit

Address and sequencing datapath for the 8-bit CPU. It sits directly downstream of the control FSM and consumes that FSM's 8-bit `state` code every clock. It owns the program counter (PC), stack pointer (SP), memory address register (MAR), instruction register (IR) and call-target latch (TMP). It produces the memory address, write strobe and write data, and feeds the fetched `instruction` back to the controller.

## Interface
- `PC_RESET`, 8'h00, PC value after reset
- `SP_RESET`, 8'hFF, SP value after reset (stack grows down)
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `state`  in  8  state code from control FSM, sampled every rising edge
- `mem_rdata`  in  8  memory read data; combinational from `mem_addr`, valid same cycle
- `reg_data`  in  8  register-file read port value (source for PUSH)
- `mem_addr`  out  8  memory address, equals MAR
- `mem_we`  out  1  memory write strobe (combinational)
- `mem_wdata`  out  8  memory write data (combinational)
- `instruction`  out  8  IR contents, to control FSM
- `io_addr`  out  8  latched port address for IN/OUT
- `pc`  out  8  current PC (debug/trace)
- `sp`  out  8  current SP (debug/trace)
- `halted`  out  1  sticky halt flag
- `stack_err`  out  1  one-cycle pulse on stack over/underflow
- `bad_state`  out  1  one-cycle pulse on an undefined state code

## Operation
Actions are applied at the rising edge, keyed on `state`. All codes come from the shared package.
- NEXT 8'h00: no action.
- FETCH_PC 8'h01: MAR<=PC; PC<=PC+1, mod 256, so 8'hFF→8'h00.
- FETCH_INST 8'h02: IR<=mem_rdata.
- HALT 8'h03: halted<=1.
- JUMP 8'h04: PC<=mem_rdata.
- SET_REG 8'h14: TMP<=mem_rdata. The register file loads the same value in parallel.
- SET_ADDR 8'h11: io_addr<=mem_rdata.
- FETCH_SP 8'h0C: MAR<=SP.
- REG_STORE 8'h13 (PUSH): mem_we=1, mem_wdata=reg_data; SP<=SP-1.
- PC_STORE 8'h0D (CALL): mem_we=1, mem_wdata=PC; SP<=SP-1.
- TMP_JUMP 8'h0E: PC<=TMP.
- INC_SP 8'h10: SP<=SP+1.
- RET 8'h0F: PC<=mem_rdata.
- OUT 8'h05, IN 8'h12, ALU_OUT 8'h06, ALU_EXEC 8'h07, MOV_STORE 8'h08, MOV_FETCH 8'h09, MOV_LOAD 8'h0A: no action in this block.
- Any other code: no register change; bad_state pulses high for one cycle on the next clock.

Boundary rules:
- SP arithmetic is mod 256.
- stack_err pulses when a decrement starts from SP==8'h00 or an increment starts from SP==8'hFF. The SP still wraps.
- While `halted`=1, every state is ignored and mem_we is forced 0. Only reset clears `halted`.
- mem_we is asserted only in REG_STORE and PC_STORE; it is never asserted during reset.
- A PC_STORE pushes the PC that already points past the CALL operand. This value is the return address.

## Timing
- Reset (reset_n=0 at a rising edge):
  - PC=PC_RESET, SP=SP_RESET.
  - MAR=0, IR=0, TMP=0, io_addr=0.
  - halted=0, stack_err=0, bad_state=0.
  - mem_we=0 while reset_n=0.
- Reset mid-instruction discards all in-flight state. No pending write completes.
- Register updates are visible one cycle after the state is sampled.
- mem_addr follows MAR with zero added latency. A FETCH_PC at edge N gives a valid mem_rdata in the cycle after edge N, which the FETCH_INST at edge N+1 captures.
- mem_we and mem_wdata are combinational from `state`, MAR, PC and reg_data. The memory writes at the same edge the state is sampled.
- stack_err and bad_state are registered. Each is high for exactly one cycle after the offending edge.

## Structure
- Shared package `cpu_pkg` holds:
  - the STATE_* localparams (8-bit codes above)
  - the OP_* opcode constants
  - width constant `DATA_W = 8`
- The control FSM and this block both import `cpu_pkg`. Neither keeps private copies of the codes.
- Single flat module, no sub-module. A separate `cpu_stack_ptr` is not warranted at this size.

## Test plan
- Reset, then FETCH_PC, FETCH_INST with memory[0]=8'h10 → mem_addr=0 during fetch, instruction=8'h10, pc=1.
- JUMP with mem_rdata=8'h42 → pc=8'h42 next cycle. FETCH_PC at PC=8'hFF → pc=8'h00, mem_addr=8'hFF.
- PUSH with SP=8'hFF, reg_data=8'hA5: FETCH_SP, REG_STORE → write 8'hA5 to 8'hFF, sp=8'hFE, no stack_err.
- CALL to 8'h30 from PC=8'h05: FETCH_PC, SET_REG (rdata 8'h30), FETCH_SP, PC_STORE, TMP_JUMP → mem[8'hFF]=8'h06, sp=8'hFE, pc=8'h30. Then RET: INC_SP, FETCH_SP, RET → pc=8'h06, sp=8'hFF.
- INC_SP at SP=8'hFF → sp=8'h00, stack_err pulses one cycle. REG_STORE at SP=8'h00 → sp=8'hFF, stack_err pulses.
- HALT, then JUMP/REG_STORE → pc, sp frozen, mem_we=0. State 8'h0B → bad_state one cycle. reset_n=0 → all outputs at reset values.
